dm_port_arbiter: RTL and testbench



---
 rtl/dm_port_arbiter_if.sv | 35 +++
 rtl/dm_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter_if
//   Request/response bundle for one requester of the data-memory arbiter.
//
//   Requester -> arbiter : req, we, acc_type, addr, wdata
//   Arbiter -> requester : gnt, rvalid, rdata, err
//
//   acc_type encoding: 0 = w, 1 = h, 2 = hu, 3 = b, 4 = bu, 5..7 illegal.
//   The field is called acc_type because "type" is a reserved word.
//
//   Modports:
//     master : the requester side (core load/store path or debug/DMA port)
//     slave  : the arbiter side
// -----------------------------------------------------------------------------
interface dm_port_arbiter_if;
  logic        req;
  logic        we;
  logic [2:0]  acc_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, acc_type, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, acc_type, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//   Shares one single-port word memory between two requesters (m0 = core
//   load/store path, m1 = debug/DMA port) with round-robin arbitration.
//   Typed sub-word accesses are turned into a word address, byte enables and
//   lane-replicated write data. The response (rvalid, extended rdata, err)
//   appears exactly one cycle after the grant.
//
//   Parameters:
//     MEM_AW        word-address width towards the memory (10 -> 1024 words)
//     PRIO_M0_FIRST requester that wins the first tie after reset (1 = m0)
//
//   Ports:
//     clk        system clock, all state on the rising edge
//     reset      synchronous, active-high reset
//     m0, m1     requester bundles (dm_port_arbiter_if.slave)
//     mem_en     memory access strobe (legal granted access only)
//     mem_we     memory write
//     mem_be     byte enables
//     mem_waddr  word address = addr[MEM_AW+1:2]
//     mem_wdata  lane-replicated write data
//     mem_rdata  word read data, valid the cycle after mem_en
//
//   Optional build macro:
//     DM_ARB_TRACE_EN  prints granted legal stores and error responses via
//                      $display (simulation only). Undefined by default.
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int MEM_AW        = 10,
  parameter bit PRIO_M0_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  dm_port_arbiter_if.slave  m0,
  dm_port_arbiter_if.slave  m1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] TYPE_W  = 3'd0;
  localparam logic [2:0] TYPE_H  = 3'd1;
  localparam logic [2:0] TYPE_HU = 3'd2;
  localparam logic [2:0] TYPE_B  = 3'd3;
  localparam logic [2:0] TYPE_BU = 3'd4;

  // ---------------------------------------------------------------------------
  // Access helpers
  // ---------------------------------------------------------------------------

  // Legal iff the type is defined and the address is naturally aligned.
  function automatic logic access_legal(input logic [2:0] t, input logic [1:0] a);
    logic ok;
    case (t)
      TYPE_W:          ok = (a == 2'b00);
      TYPE_H, TYPE_HU: ok = (a[0] == 1'b0);
      TYPE_B, TYPE_BU: ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] t, input logic [1:0] a);
    logic [3:0] be;
    case (t)
      TYPE_W:          be = 4'b1111;
      TYPE_H, TYPE_HU: be = a[1] ? 4'b1100 : 4'b0011;
      TYPE_B, TYPE_BU: be = 4'b0001 << a;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low-aligned store data across every lane it could land in,
  // so the memory only has to honour the byte enables.
  function automatic logic [31:0] lane_wdata(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] wd;
    case (t)
      TYPE_W:          wd = d;
      TYPE_H, TYPE_HU: wd = {2{d[15:0]}};
      TYPE_B, TYPE_BU: wd = {4{d[7:0]}};
      default:         wd = 32'h0000_0000;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (t)
      TYPE_W:  res = word;
      TYPE_H:  res = {{16{half_v[15]}}, half_v};
      TYPE_HU: res = {16'h0000, half_v};
      TYPE_B:  res = {{24{byte_v[7]}}, byte_v};
      TYPE_BU: res = {24'h00_0000, byte_v};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------

  // last_r = 1'b1 means m1 was granted most recently, so m0 wins the next tie.
  logic        last_r;
  logic        gnt0_s;
  logic        gnt1_s;
  logic        gnt_any_s;
  logic        sel_we_s;
  logic [2:0]  sel_type_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_legal_s;

  // Round-robin grant; nothing is granted while reset is asserted.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (m0.req && m1.req) begin
      gnt0_s = last_r;
      gnt1_s = ~last_r;
    end else if (m0.req) begin
      gnt0_s = 1'b1;
    end else if (m1.req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign gnt_any_s = gnt0_s | gnt1_s;
  assign m0.gnt    = gnt0_s;
  assign m1.gnt    = gnt1_s;

  // Route the granted requester's fields to the memory-side decode.
  always_comb begin
    sel_we_s    = m0.we;
    sel_type_s  = m0.acc_type;
    sel_addr_s  = m0.addr;
    sel_wdata_s = m0.wdata;
    if (gnt1_s) begin
      sel_we_s    = m1.we;
      sel_type_s  = m1.acc_type;
      sel_addr_s  = m1.addr;
      sel_wdata_s = m1.wdata;
    end else begin
      sel_we_s    = m0.we;
      sel_type_s  = m0.acc_type;
      sel_addr_s  = m0.addr;
      sel_wdata_s = m0.wdata;
    end
  end

  assign sel_legal_s = access_legal(sel_type_s, sel_addr_s[1:0]);

  // ---------------------------------------------------------------------------
  // Memory request
  // ---------------------------------------------------------------------------

  // Illegal accesses are granted (so they get an err response) but never
  // reach the memory; the bus is held quiet whenever mem_en is low.
  always_comb begin
    mem_en    = gnt_any_s & sel_legal_s;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_waddr = '0;
    mem_wdata = 32'h0000_0000;
    if (gnt_any_s && sel_legal_s) begin
      mem_we    = sel_we_s;
      mem_be    = byte_enables(sel_type_s, sel_addr_s[1:0]);
      mem_waddr = sel_addr_s[MEM_AW+1:2];
      mem_wdata = lane_wdata(sel_type_s, sel_wdata_s);
    end else begin
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_waddr = '0;
      mem_wdata = 32'h0000_0000;
    end
  end

  // Address bits above the memory window are deliberately ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^sel_addr_s[31:MEM_AW+2];

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------

  logic        rsp_valid_r;
  logic        rsp_owner_r;   // 0 = m0, 1 = m1
  logic        rsp_we_r;
  logic [2:0]  rsp_type_r;
  logic [1:0]  rsp_lane_r;
  logic        rsp_err_r;
  logic [31:0] rsp_data_s;
  logic        rvalid0_s;
  logic        rvalid1_s;
  logic [31:0] rdata0_r;
  logic [31:0] rdata1_r;
  logic        err0_r;
  logic        err1_r;

  // Round-robin pointer and grant-edge capture of the response context.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r      <= PRIO_M0_FIRST ? 1'b1 : 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_owner_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_type_r  <= 3'd0;
      rsp_lane_r  <= 2'b00;
      rsp_err_r   <= 1'b0;
    end else begin
      last_r      <= gnt_any_s ? gnt1_s : last_r;
      rsp_valid_r <= gnt_any_s;
      rsp_owner_r <= gnt1_s;
      rsp_we_r    <= sel_we_s;
      rsp_type_r  <= sel_type_s;
      rsp_lane_r  <= sel_addr_s[1:0];
      rsp_err_r   <= ~sel_legal_s;
    end
  end

  // mem_rdata is only meaningful in the response cycle, so the extended load
  // value is formed combinationally there and captured for holding afterwards.
  assign rsp_data_s = (rsp_we_r || rsp_err_r) ? 32'h0000_0000
                                              : load_extend(rsp_type_r, rsp_lane_r, mem_rdata);

  // Gating with reset drops a response that was pending when reset arrived.
  assign rvalid0_s = rsp_valid_r & ~rsp_owner_r & ~reset;
  assign rvalid1_s = rsp_valid_r &  rsp_owner_r & ~reset;

  // Per-master hold registers: rdata/err stay put until that master's next rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_r <= 32'h0000_0000;
      rdata1_r <= 32'h0000_0000;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
    end else begin
      if (rvalid0_s) begin
        rdata0_r <= rsp_data_s;
        err0_r   <= rsp_err_r;
      end
      if (rvalid1_s) begin
        rdata1_r <= rsp_data_s;
        err1_r   <= rsp_err_r;
      end
    end
  end

  assign m0.rvalid = rvalid0_s;
  assign m1.rvalid = rvalid1_s;
  assign m0.rdata  = rvalid0_s ? rsp_data_s : rdata0_r;
  assign m1.rdata  = rvalid1_s ? rsp_data_s : rdata1_r;
  assign m0.err    = rvalid0_s ? rsp_err_r  : err0_r;
  assign m1.err    = rvalid1_s ? rsp_err_r  : err1_r;

`ifdef DM_ARB_TRACE_EN
  logic [31:0] trace_addr_r;

  // Full byte address of the last grant, kept only for the error trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_addr_r <= 32'h0000_0000;
    end else begin
      trace_addr_r <= sel_addr_s;
    end
  end

  // Simulation trace of legal stores at grant and of error responses.
  always_ff @(posedge clk) begin
    if (!reset && mem_en && mem_we) begin
      $display("@m%0d: *%h <= %h", gnt1_s, sel_addr_s, sel_wdata_s);
    end
    if (!reset && rsp_valid_r && rsp_err_r) begin
      $display("@m%0d: bad access %h type %0d", rsp_owner_r, trace_addr_r, rsp_type_r);
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
//   Directed, table-driven bench for dm_port_arbiter. A byte-enabled word
//   memory model with one-cycle read latency sits on the memory port. Inputs
//   change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam logic [2:0] T_W  = 3'd0;
  localparam logic [2:0] T_H  = 3'd1;
  localparam logic [2:0] T_HU = 3'd2;
  localparam logic [2:0] T_B  = 3'd3;
  localparam logic [2:0] T_BU = 3'd4;
  localparam logic [2:0] T_X5 = 3'd5;

  logic        clk;
  logic        reset;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_clr;
  logic [31:0] mem_model [0:1023];

  int checks;
  int errors;

  dm_port_arbiter_if m0_if ();
  dm_port_arbiter_if m1_if ();

  dm_port_arbiter #(
    .MEM_AW        (10),
    .PRIO_M0_FIRST (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-enabled write, registered read of the addressed word.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_model[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem_model[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      mem_rdata <= mem_model[mem_waddr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    m0_if.req = r; m0_if.we = we; m0_if.acc_type = t; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic drive1(input logic r, input logic we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d);
    m1_if.req = r; m1_if.we = we; m1_if.acc_type = t; m1_if.addr = a; m1_if.wdata = d;
  endtask

  task automatic idle_both();
    drive0(1'b0, 1'b0, T_W, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, T_W, 32'h0, 32'h0);
  endtask

  // One cycle of the vector table: requests in, grant-cycle memory outputs
  // and the response for the previous row's grant out.
  typedef struct {
    logic        r0; logic we0; logic [2:0] t0; logic [31:0] a0; logic [31:0] d0;
    logic        r1; logic we1; logic [2:0] t1; logic [31:0] a1; logic [31:0] d1;
    logic        g0; logic g1; logic en; logic we; logic [3:0] be; logic [9:0] wa;
    logic [31:0] wd;
    logic        v0; logic v1; logic [31:0] rd0; logic e0; logic [31:0] rd1; logic e1;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  initial begin
    checks = 0;
    errors = 0;

    //           m0: r we t     a      d              m1: r we t     a      d
    //           g0 g1 en we be     wa    wd            v0 v1 rd0   e0 rd1  e1
    vec[0]  = '{1'b1,1'b1,T_W ,32'h10,32'hDEADBEEF, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b1,1'b0,1'b1,1'b1,4'b1111,10'd4,32'hDEADBEEF,
                1'b0,1'b0,32'h0,1'b0,32'h0,1'b0};
    vec[1]  = '{1'b1,1'b0,T_B ,32'h13,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b1,1'b0,1'b1,1'b0,4'b1000,10'd4,32'h0,
                1'b1,1'b0,32'h0,1'b0,32'h0,1'b0};
    vec[2]  = '{1'b1,1'b0,T_BU,32'h13,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b1,1'b0,1'b1,1'b0,4'b1000,10'd4,32'h0,
                1'b1,1'b0,32'hFFFFFFDE,1'b0,32'h0,1'b0};
    vec[3]  = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b1,1'b1,T_H ,32'h22,32'h00001234,
                1'b0,1'b1,1'b1,1'b1,4'b1100,10'd8,32'h12341234,
                1'b1,1'b0,32'h000000DE,1'b0,32'h0,1'b0};
    vec[4]  = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b1,1'b0,T_H ,32'h22,32'h0,
                1'b0,1'b1,1'b1,1'b0,4'b1100,10'd8,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h0,1'b0};
    vec[5]  = '{1'b1,1'b0,T_W ,32'h06,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b1,1'b0,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h00001234,1'b0};
    vec[6]  = '{1'b1,1'b0,T_X5,32'h00,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b1,1'b0,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b1,1'b0,32'h0,1'b1,32'h0,1'b0};
    vec[7]  = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b0,1'b0,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b1,1'b0,32'h0,1'b1,32'h0,1'b0};
    vec[8]  = '{1'b1,1'b0,T_W ,32'h10,32'h0, 1'b1,1'b0,T_BU,32'h23,32'h0,
                1'b0,1'b1,1'b1,1'b0,4'b1000,10'd8,32'h0,
                1'b0,1'b0,32'h0,1'b0,32'h0,1'b0};
    vec[9]  = '{1'b1,1'b0,T_W ,32'h10,32'h0, 1'b1,1'b0,T_B ,32'h20,32'h0,
                1'b1,1'b0,1'b1,1'b0,4'b1111,10'd4,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h00000012,1'b0};
    vec[10] = '{1'b1,1'b0,T_H ,32'h12,32'h0, 1'b1,1'b0,T_B ,32'h20,32'h0,
                1'b0,1'b1,1'b1,1'b0,4'b0001,10'd8,32'h0,
                1'b1,1'b0,32'hDEADBEEF,1'b0,32'h0,1'b0};
    vec[11] = '{1'b1,1'b0,T_H ,32'h12,32'h0, 1'b1,1'b0,T_HU,32'h10,32'h0,
                1'b1,1'b0,1'b1,1'b0,4'b1100,10'd4,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h0,1'b0};
    vec[12] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b1,1'b0,T_HU,32'h10,32'h0,
                1'b0,1'b1,1'b1,1'b0,4'b0011,10'd4,32'h0,
                1'b1,1'b0,32'hFFFFDEAD,1'b0,32'h0,1'b0};
    vec[13] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b0,1'b0,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h0000BEEF,1'b0};
    vec[14] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b1,1'b1,T_B ,32'h21,32'h000000A5,
                1'b0,1'b1,1'b1,1'b1,4'b0010,10'd8,32'hA5A5A5A5,
                1'b0,1'b0,32'h0,1'b0,32'h0,1'b0};
    vec[15] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b1,1'b0,T_B ,32'h21,32'h0,
                1'b0,1'b1,1'b1,1'b0,4'b0010,10'd8,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h0,1'b0};
    vec[16] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b0,1'b0,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'hFFFFFFA5,1'b0};
    vec[17] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b1,1'b1,T_H ,32'h23,32'h0000FFFF,
                1'b0,1'b1,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b0,1'b0,32'h0,1'b0,32'h0,1'b0};
    vec[18] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b0,1'b0,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h0,1'b1};
    vec[19] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b1,1'b0,T_HU,32'h22,32'h0,
                1'b0,1'b1,1'b1,1'b0,4'b1100,10'd8,32'h0,
                1'b0,1'b0,32'h0,1'b0,32'h0,1'b0};
    vec[20] = '{1'b0,1'b0,T_W ,32'h00,32'h0, 1'b0,1'b0,T_W ,32'h00,32'h0,
                1'b0,1'b0,1'b0,1'b0,4'b0000,10'd0,32'h0,
                1'b0,1'b1,32'h0,1'b0,32'h00001234,1'b0};

    // ---- reset state, with both requesters asking for a store ----
    reset   = 1'b1;
    mem_clr = 1'b1;
    drive0(1'b1, 1'b1, T_W, 32'h40, 32'h11111111);
    drive1(1'b1, 1'b1, T_W, 32'h44, 32'h22222222);
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    chk1 ("rst_gnt0",   m0_if.gnt,    1'b0);
    chk1 ("rst_gnt1",   m1_if.gnt,    1'b0);
    chk1 ("rst_mem_en", mem_en,       1'b0);
    chk1 ("rst_rvalid0", m0_if.rvalid, 1'b0);
    chk1 ("rst_rvalid1", m1_if.rvalid, 1'b0);
    chk32("rst_rdata0", m0_if.rdata,  32'h0);
    chk32("rst_rdata1", m1_if.rdata,  32'h0);
    chk1 ("rst_err0",   m0_if.err,    1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle_both();

    // ---- both requesting every cycle: strict alternation starting at m0 ----
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      drive0(1'b1, 1'b0, T_W, 32'h0, 32'h0);
      drive1(1'b1, 1'b0, T_W, 32'h4, 32'h0);
      @(negedge clk);
      chk1($sformatf("alt%0d_gnt0", i),    m0_if.gnt,    (i % 2) == 0);
      chk1($sformatf("alt%0d_gnt1", i),    m1_if.gnt,    (i % 2) == 1);
      chk1($sformatf("alt%0d_rvalid0", i), m0_if.rvalid, (i > 0) && ((i % 2) == 1));
      chk1($sformatf("alt%0d_rvalid1", i), m1_if.rvalid, (i > 0) && ((i % 2) == 0));
    end
    @(posedge clk);
    #1 idle_both();
    @(negedge clk);
    chk1("alt_tail_rvalid0", m0_if.rvalid, 1'b0);
    chk1("alt_tail_rvalid1", m1_if.rvalid, 1'b1);

    // ---- vector table ----
    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      drive0(vec[k].r0, vec[k].we0, vec[k].t0, vec[k].a0, vec[k].d0);
      drive1(vec[k].r1, vec[k].we1, vec[k].t1, vec[k].a1, vec[k].d1);
      @(negedge clk);
      chk1($sformatf("row%0d_gnt0", k),    m0_if.gnt,    vec[k].g0);
      chk1($sformatf("row%0d_gnt1", k),    m1_if.gnt,    vec[k].g1);
      chk1($sformatf("row%0d_mem_en", k),  mem_en,       vec[k].en);
      chk1($sformatf("row%0d_rvalid0", k), m0_if.rvalid, vec[k].v0);
      chk1($sformatf("row%0d_rvalid1", k), m1_if.rvalid, vec[k].v1);
      if (vec[k].en) begin
        chk1 ($sformatf("row%0d_mem_we", k),    mem_we,    vec[k].we);
        chk32($sformatf("row%0d_mem_be", k),    {28'h0, mem_be},    {28'h0, vec[k].be});
        chk32($sformatf("row%0d_mem_waddr", k), {22'h0, mem_waddr}, {22'h0, vec[k].wa});
        chk32($sformatf("row%0d_mem_wdata", k), mem_wdata, vec[k].wd);
      end
      if (vec[k].v0) begin
        chk32($sformatf("row%0d_rdata0", k), m0_if.rdata, vec[k].rd0);
        chk1 ($sformatf("row%0d_err0", k),   m0_if.err,   vec[k].e0);
      end
      if (vec[k].v1) begin
        chk32($sformatf("row%0d_rdata1", k), m1_if.rdata, vec[k].rd1);
        chk1 ($sformatf("row%0d_err1", k),   m1_if.err,   vec[k].e1);
      end
    end

    // ---- response data is held after the rvalid pulse ----
    @(posedge clk);
    #1 idle_both();
    @(negedge clk);
    chk1 ("hold_rvalid1", m1_if.rvalid, 1'b0);
    chk32("hold_rdata1",  m1_if.rdata,  32'h00001234);
    chk1 ("hold_err1",    m1_if.err,    1'b0);

    // ---- only m1 for three cycles, then m0 joins and wins the tie ----
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 drive1(1'b1, 1'b0, T_W, 32'h0, 32'h0);
      @(negedge clk);
      chk1($sformatf("solo%0d_gnt1", i), m1_if.gnt, 1'b1);
      chk1($sformatf("solo%0d_gnt0", i), m0_if.gnt, 1'b0);
    end
    @(posedge clk);
    #1 drive0(1'b1, 1'b0, T_W, 32'h0, 32'h0);
    @(negedge clk);
    chk1("join_gnt0", m0_if.gnt, 1'b1);
    chk1("join_gnt1", m1_if.gnt, 1'b0);
    @(posedge clk);
    #1 idle_both();
    @(posedge clk);

    // ---- reset while a store response is pending ----
    #1 drive0(1'b1, 1'b1, T_W, 32'h30, 32'h00000055);
    @(negedge clk);
    chk1("pre_rst_gnt0", m0_if.gnt, 1'b1);
    chk1("pre_rst_en",   mem_en,    1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive0(1'b1, 1'b1, T_W, 32'h40, 32'h00000077);
    @(negedge clk);
    chk1("mid_rst_rvalid0", m0_if.rvalid, 1'b0);
    chk1("mid_rst_mem_en",  mem_en,       1'b0);
    chk1("mid_rst_gnt0",    m0_if.gnt,    1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive0(1'b1, 1'b0, T_W, 32'h40, 32'h0);
    drive1(1'b1, 1'b0, T_W, 32'h30, 32'h0);
    @(negedge clk);
    chk1("post_rst_gnt0",    m0_if.gnt,    1'b1);
    chk1("post_rst_gnt1",    m1_if.gnt,    1'b0);
    chk1("post_rst_rvalid0", m0_if.rvalid, 1'b0);
    chk1("post_rst_rvalid1", m1_if.rvalid, 1'b0);
    @(posedge clk);
    #1 drive0(1'b0, 1'b0, T_W, 32'h0, 32'h0);
    @(negedge clk);
    chk1 ("post_rst_gnt1b",  m1_if.gnt,    1'b1);
    chk1 ("post_rst_rv0",    m0_if.rvalid, 1'b1);
    chk32("reset_store_dropped", m0_if.rdata, 32'h0);
    @(posedge clk);
    #1 idle_both();
    @(negedge clk);
    chk1 ("post_rst_rv1",    m1_if.rvalid, 1'b1);
    chk32("pre_reset_store_kept", m1_if.rdata, 32'h00000055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
